// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
package div_pkg;
  typedef enum logic [1:0] {DIV_ = 2'd0, DIVU_ = 2'd1, REM_ = 2'd2, REMU_ = 2'd3} div_ops_e;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [1:0]            operation_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  data_valid_o,
  output logic                  divide_by_zero_o,
  output logic                  fu_state_o
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREPARE, DIVIDE, RESTORE, DONE} state_e;
  state_e state_q, state_d;

  logic [DW-1:0] rem_q, quo_q, dsr_q, res_q;
  logic [1:0]    op_q;
  logic          neg_quo_q, neg_rem_q, dbz_q;
  logic [CW-1:0] cnt_q;

  // Encoding: bit1 selects remainder, bit0 clear means signed.
  logic in_rem, in_signed, div_zero, div_ovf, special;
  logic [DW-1:0] special_res;
  assign in_rem    = operation_i[1];
  assign in_signed = ~operation_i[0];
  assign div_zero  = (divisor_i == '0);
  assign div_ovf   = in_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
  assign special   = div_zero | div_ovf;
  always_comb begin
    special_res = '0;
    if (div_zero)    special_res = in_rem ? dividend_i : '1;
    else if (div_ovf) special_res = in_rem ? '0 : INT_MIN;
  end

  // Shifted partial remainder is DW+1 bits wide; the top bit of the difference is the borrow.
  logic [DW:0] trial;
  assign trial = {rem_q, quo_q[DW-1]} - {1'b0, dsr_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_valid_i) state_d = special ? DONE : PREPARE;
      PREPARE: state_d = DIVIDE;
      DIVIDE:  if (cnt_q == CW'(DW - 1)) state_d = RESTORE;
      RESTORE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_comb begin
    fu_state_o = (state_q == IDLE) ? FREE : BUSY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0; quo_q <= '0; dsr_q <= '0; res_q <= '0;
      op_q <= '0; neg_quo_q <= 1'b0; neg_rem_q <= 1'b0; dbz_q <= 1'b0;
      cnt_q <= '0;
      result_o <= '0; data_valid_o <= 1'b0; divide_by_zero_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      if (!clear_i) begin
        case (state_q)
          IDLE: if (data_valid_i) begin
            op_q  <= operation_i;
            quo_q <= dividend_i;
            dsr_q <= divisor_i;
            rem_q <= '0;
            cnt_q <= '0;
            res_q <= special_res;
            dbz_q <= div_zero;
          end
          PREPARE: begin
            if (!op_q[0]) begin
              quo_q     <= quo_q[DW-1] ? -quo_q : quo_q;
              dsr_q     <= dsr_q[DW-1] ? -dsr_q : dsr_q;
              neg_quo_q <= quo_q[DW-1] ^ dsr_q[DW-1];
              neg_rem_q <= quo_q[DW-1];
            end else begin
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end
          end
          DIVIDE: begin
            rem_q <= trial[DW] ? {rem_q[DW-2:0], quo_q[DW-1]} : trial[DW-1:0];
            quo_q <= {quo_q[DW-2:0], ~trial[DW]};
            cnt_q <= cnt_q + CW'(1);
          end
          RESTORE: begin
            if (op_q[1]) res_q <= neg_rem_q ? -rem_q : rem_q;
            else         res_q <= neg_quo_q ? -quo_q : quo_q;
          end
          DONE: begin
            result_o         <= res_q;
            divide_by_zero_o <= dbz_q;
            data_valid_o     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: normal, signed, special-case,
// busy-ignore, clear and mid-operation reset scenarios.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear, dv;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic [31:0] result_o;
  logic        data_valid_o, divide_by_zero_o, fu_state_o;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .data_valid_i(dv),
    .dividend_i(a), .divisor_i(b), .operation_i(op),
    .result_o(result_o), .data_valid_o(data_valid_o),
    .divide_by_zero_o(divide_by_zero_o), .fu_state_o(fu_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    dv = 1'b1; op = o; a = x; b = y;
    tick();
    dv = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (data_valid_o !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_r, input logic exp_z,
                     input int exp_lat);
    int lat = 0;
    issue(o, x, y);
    wait_done(lat);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, result_o, exp_r);
    check({tag, ".dbz"}, {31'd0, divide_by_zero_o}, {31'd0, exp_z});
    tick();
    check({tag, ".pulse"}, {31'd0, data_valid_o}, 32'd0);
    check({tag, ".hold"}, result_o, exp_r);
    check({tag, ".free"}, {31'd0, fu_state_o}, {31'd0, FREE});
  endtask

  task automatic no_pulse(input string tag, input int cycles);
    int p = 0;
    repeat (cycles) begin
      tick();
      if (data_valid_o) p++;
    end
    check(tag, 32'(p), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; clear = 1'b0; dv = 1'b0; a = '0; b = '0; op = '0;
    repeat (3) tick();
    check("rst.res", result_o, 32'd0);
    check("rst.vld", {31'd0, data_valid_o}, 32'd0);
    check("rst.dbz", {31'd0, divide_by_zero_o}, 32'd0);
    check("rst.fu", {31'd0, fu_state_o}, {31'd0, FREE});
    @(negedge clk); rst = 1'b0;

    run("divu_100_7", DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 35);
    run("remu_100_7", REMU_, 32'd100, 32'd7, 32'd2, 1'b0, 35);
    run("div_m7_2",   DIV_,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 35);
    run("rem_m7_2",   REM_,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 35);
    run("div_7_m2",   DIV_,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 35);
    run("rem_7_m2",   REM_,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 35);
    run("div_m100_7", DIV_,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 35);
    run("rem_m100_7", REM_,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, 35);
    run("divu_max_1", DIVU_, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 35);
    run("remu_max_16", REMU_, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 35);
    run("divu_big",   DIVU_, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 35);
    run("div_5_0",    DIV_,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run("remu_5_0",   REMU_, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    run("div_ovf",    DIV_,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run("rem_ovf",    REM_,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

    // Second request while busy must be ignored
    lat = 0;
    issue(DIVU_, 32'd1000, 32'd10);
    check("busy.fu", {31'd0, fu_state_o}, {31'd0, BUSY});
    repeat (5) begin tick(); lat++; end
    @(negedge clk); dv = 1'b1; op = DIVU_; a = 32'd9; b = 32'd3;
    tick(); lat++; dv = 1'b0;
    wait_done(lat);
    check("busy.lat", 32'(lat), 32'd35);
    check("busy.res", result_o, 32'd100);
    tick();
    run("reissue", DIVU_, 32'd9, 32'd3, 32'd3, 1'b0, 35);

    // Flush 10 cycles into the divide loop
    issue(DIVU_, 32'd100, 32'd7);
    repeat (11) tick();
    @(negedge clk); clear = 1'b1;
    tick(); clear = 1'b0;
    check("clr.fu", {31'd0, fu_state_o}, {31'd0, FREE});
    no_pulse("clr.nopulse", 40);
    check("clr.hold", result_o, 32'd3);

    // Request coinciding with flush in IDLE is dropped
    @(negedge clk); dv = 1'b1; clear = 1'b1; op = DIVU_; a = 32'd50; b = 32'd5;
    tick(); dv = 1'b0; clear = 1'b0;
    check("clrdv.fu", {31'd0, fu_state_o}, {31'd0, FREE});
    no_pulse("clrdv.nopulse", 40);

    // Reset mid-operation with nonzero held outputs
    run("pre_rst", DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    issue(DIVU_, 32'd100, 32'd7);
    repeat (20) tick();
    @(negedge clk); rst = 1'b1;
    tick(); rst = 1'b0;
    check("mrst.res", result_o, 32'd0);
    check("mrst.dbz", {31'd0, divide_by_zero_o}, 32'd0);
    check("mrst.vld", {31'd0, data_valid_o}, 32'd0);
    check("mrst.fu", {31'd0, fu_state_o}, {31'd0, FREE});
    no_pulse("mrst.nopulse", 40);
    run("post_rst", DIVU_, 32'd100, 32'd7, 32'd14, 1'b0, 35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
